// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add/compare ops, bit-serial MUL and
// restoring DIV/REM, with a valid/ready request and result handshake.
module alu_mc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          SIGNED_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  div_zero,
  output logic                  illegal_op
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_REM = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic            rdy_q;
  logic            accept;
  logic            sgn;
  logic [3:0]      op_q;
  logic            q_neg_q, r_neg_q;
  logic [W-1:0]    acc_q, mcand_q, mplier_q;
  logic [W-1:0]    rem_q, quo_q, bmag_q;
  logic [CW-1:0]   cnt_q;
  logic            last;

  logic [W:0]      sum, dif;
  logic            lt, eq, gt;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W-1:0]    imm_res;
  logic            imm_carry, imm_dz, imm_ill, multi;

  logic [W-1:0]    mul_nx;
  logic [W:0]      shifted;
  logic            ge;
  logic [W-1:0]    trial, rem_nx, quo_nx, q_fin, r_fin;

  // rdy_q keeps in_ready low until the first clock edge after reset release
  assign in_ready  = rdy_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign sgn       = SIGNED_EN && is_signed;
  assign last      = (cnt_q == CW'(W - 1));

  // Decode the request and compute all single-cycle results from live inputs
  always_comb begin
    sum       = {1'b0, rs_data} + {1'b0, rt_data};
    dif       = {1'b0, rs_data} - {1'b0, rt_data};
    lt        = sgn ? ($signed(rs_data) < $signed(rt_data)) : (rs_data < rt_data);
    eq        = (rs_data == rt_data);
    gt        = !lt && !eq;
    a_neg     = sgn && rs_data[W-1];
    b_neg     = sgn && rt_data[W-1];
    a_mag     = a_neg ? -rs_data : rs_data;
    b_mag     = b_neg ? -rt_data : rt_data;
    imm_res   = '0;
    imm_carry = 1'b0;
    imm_dz    = 1'b0;
    imm_ill   = 1'b0;
    multi     = 1'b0;
    case (op)
      OP_ADD: begin imm_res = sum[W-1:0]; imm_carry = sum[W]; end
      OP_SUB: begin imm_res = dif[W-1:0]; imm_carry = dif[W]; end
      OP_MUL: multi = 1'b1;
      OP_DIV: if (rt_data == '0) begin imm_res = '1; imm_dz = 1'b1; end
              else multi = 1'b1;
      OP_REM: if (rt_data == '0) begin imm_res = rs_data; imm_dz = 1'b1; end
              else multi = 1'b1;
      OP_CMP: imm_res = {{(W-3){1'b0}}, lt, eq, gt};
      OP_AND: imm_res = rs_data & rt_data;
      OP_OR:  imm_res = rs_data | rt_data;
      OP_XOR: imm_res = rs_data ^ rt_data;
      default: imm_ill = 1'b1;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step per BUSY cycle
  always_comb begin
    mul_nx  = acc_q + (mplier_q[0] ? mcand_q : '0);
    shifted = {rem_q, quo_q[W-1]};
    ge      = (shifted >= {1'b0, bmag_q});
    trial   = shifted[W-1:0] - bmag_q;
    rem_nx  = ge ? trial : shifted[W-1:0];
    quo_nx  = {quo_q[W-2:0], ge};
    q_fin   = q_neg_q ? -quo_nx : quo_nx;
    r_fin   = r_neg_q ? -rem_nx : rem_nx;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = multi ? BUSY : DONE;
      BUSY: if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iterative datapath and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q      <= 1'b0;
      op_q       <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      bmag_q     <= '0;
      cnt_q      <= '0;
      result     <= '0;
      carry      <= 1'b0;
      div_zero   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        op_q       <= op;
        q_neg_q    <= a_neg ^ b_neg;
        r_neg_q    <= a_neg;
        acc_q      <= '0;
        mcand_q    <= rs_data;
        mplier_q   <= rt_data;
        rem_q      <= '0;
        quo_q      <= a_mag;
        bmag_q     <= b_mag;
        cnt_q      <= '0;
        result     <= imm_res;
        carry      <= imm_carry;
        div_zero   <= imm_dz;
        illegal_op <= imm_ill;
      end else if (state_q == BUSY) begin
        cnt_q    <= cnt_q + CW'(1);
        acc_q    <= mul_nx;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        rem_q    <= rem_nx;
        quo_q    <= quo_nx;
        if (last) begin
          if (op_q == OP_MUL)      result <= mul_nx;
          else if (op_q == OP_DIV) result <= q_fin;
          else                     result <= r_fin;
        end
      end
    end
  end

endmodule
